// File: rtl/ldtu_fifo_read_ctrl.sv
// Read-side scheduler for the LDTU output buffer: answers serializer word
// requests with SYNC words, IDLE words, or one popped FIFO word per request.
module ldtu_fifo_read_ctrl #(
  parameter int unsigned     Nbits_32  = 32,
  parameter logic [Nbits_32-1:0] IDLE_WORD = 32'hE0000000,
  parameter logic [Nbits_32-1:0] SYNC_WORD = 32'hEAAAAAAA,
  parameter int unsigned     CNT_BITS  = 16
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                sync_mode,
  input  logic                word_req,
  input  logic                fifo_empty,
  input  logic [Nbits_32-1:0] fifo_rd_data,
  output logic                fifo_rd_en,
  output logic [Nbits_32-1:0] DATA_out,
  output logic                data_valid,
  output logic [CNT_BITS-1:0] idle_cnt,
  output logic                req_overrun
);

  typedef enum logic [1:0] {StSync, StWait, StFetch, StLoad} state_e;

  state_e              state_q, state_d;
  logic [Nbits_32-1:0] data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                rd_en_q, rd_en_d;
  logic [CNT_BITS-1:0] idle_cnt_q, idle_cnt_d;
  logic                overrun_q, overrun_d;

  // Next-state and next-output decision for the current state.
  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    rd_en_d      = 1'b0;
    idle_cnt_d   = idle_cnt_q;
    overrun_d    = overrun_q;
    unique case (state_q)
      StSync: begin
        if (word_req) begin
          data_out_d   = SYNC_WORD;
          data_valid_d = 1'b1;
        end
        if (!sync_mode) state_d = StWait;
      end
      StWait: begin
        if (sync_mode) begin
          // Alignment takes precedence; a coincident request still gets SYNC.
          state_d = StSync;
          if (word_req) begin
            data_out_d   = SYNC_WORD;
            data_valid_d = 1'b1;
          end
        end else if (word_req) begin
          if (!fifo_empty) begin
            rd_en_d = 1'b1;
            state_d = StFetch;
          end else begin
            data_out_d   = IDLE_WORD;
            data_valid_d = 1'b1;
            if (idle_cnt_q != {CNT_BITS{1'b1}}) idle_cnt_d = idle_cnt_q + CNT_BITS'(1);
          end
        end
      end
      StFetch: begin
        // FIFO registers its output during this cycle; read data is valid in LOAD.
        if (word_req) overrun_d = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        if (word_req) overrun_d = 1'b1;
        data_out_d   = fifo_rd_data;
        data_valid_d = 1'b1;
        state_d      = sync_mode ? StSync : StWait;
      end
      default: state_d = StSync;
    endcase
  end

  // State and registered outputs; async reset aborts any in-flight fetch.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StSync;
      data_out_q   <= SYNC_WORD;
      data_valid_q <= 1'b0;
      rd_en_q      <= 1'b0;
      idle_cnt_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      rd_en_q      <= rd_en_d;
      idle_cnt_q   <= idle_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign DATA_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign idle_cnt    = idle_cnt_q;
  assign req_overrun = overrun_q;

endmodule

// File: tb/tb_ldtu_fifo_read_ctrl.sv
// Directed bench for ldtu_fifo_read_ctrl; outputs sampled 1 time unit after
// the rising edge.
module tb_ldtu_fifo_read_ctrl;

  localparam logic [31:0] Idle = 32'hE0000000;
  localparam logic [31:0] Sync = 32'hEAAAAAAA;

  logic        CLK = 1'b0;
  logic        rst_b;
  logic        sync_mode;
  logic        word_req;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic [31:0] DATA_out;
  logic        data_valid;
  logic [15:0] idle_cnt;
  logic        req_overrun;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ldtu_fifo_read_ctrl dut (
    .CLK          (CLK),
    .rst_b        (rst_b),
    .sync_mode    (sync_mode),
    .word_req     (word_req),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .DATA_out     (DATA_out),
    .data_valid   (data_valid),
    .idle_cnt     (idle_cnt),
    .req_overrun  (req_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] data, input logic vld,
                           input logic rd);
    check({tag, ".data"}, DATA_out, data);
    check({tag, ".valid"}, {31'b0, data_valid}, {31'b0, vld});
    check({tag, ".rd_en"}, {31'b0, fifo_rd_en}, {31'b0, rd});
  endtask

  initial begin
    rst_b = 1'b0; sync_mode = 1'b1; word_req = 1'b0; fifo_empty = 1'b1;
    fifo_rd_data = 32'h0;
    #12;
    check_out("rst", Sync, 1'b0, 1'b0);
    check("rst.idle_cnt", {16'b0, idle_cnt}, 32'd0);
    check("rst.overrun", {31'b0, req_overrun}, 32'd0);
    step();
    rst_b = 1'b1;

    // 1: sync mode, three requests each answered one cycle later
    for (int i = 0; i < 3; i++) begin
      word_req = 1'b1; step();
      check_out("sync_req", Sync, 1'b1, 1'b0);
      word_req = 1'b0; step();
      check_out("sync_gap", Sync, 1'b0, 1'b0);
    end

    // 2: idle word on empty FIFO
    sync_mode = 1'b0; step();
    word_req = 1'b1; step();
    check_out("idle", Idle, 1'b1, 1'b0);
    check("idle.cnt", {16'b0, idle_cnt}, 32'd1);
    word_req = 1'b0; step();
    check_out("idle_hold", Idle, 1'b0, 1'b0);

    // 3: FIFO word, 3-cycle latency
    fifo_empty = 1'b0; fifo_rd_data = 32'h5A5A0001; word_req = 1'b1; step();
    check_out("fetch_t1", Idle, 1'b0, 1'b1);
    word_req = 1'b0; step();
    check_out("fetch_t2", Idle, 1'b0, 1'b0);
    step();
    check_out("fetch_t3", 32'h5A5A0001, 1'b1, 1'b0);
    check("fetch.overrun", {31'b0, req_overrun}, 32'd0);
    step();
    check_out("fetch_t4", 32'h5A5A0001, 1'b0, 1'b0);

    // 4: back-to-back requests during a fetch -> one pop, one word, overrun
    fifo_rd_data = 32'h12345678; word_req = 1'b1; step();
    check_out("ovr_t1", 32'h5A5A0001, 1'b0, 1'b1);
    step();
    check_out("ovr_t2", 32'h5A5A0001, 1'b0, 1'b0);
    check("ovr_t2.overrun", {31'b0, req_overrun}, 32'd1);
    step();
    check_out("ovr_t3", 32'h12345678, 1'b1, 1'b0);
    word_req = 1'b0; step();
    check_out("ovr_t4", 32'h12345678, 1'b0, 1'b0);
    check("ovr.sticky", {31'b0, req_overrun}, 32'd1);

    // 5: sync_mode rises mid-fetch; in-flight word delivered, then SYNC
    fifo_rd_data = 32'hC0DE0005; word_req = 1'b1; step();
    check_out("s5_t1", 32'h12345678, 1'b0, 1'b1);
    word_req = 1'b0; sync_mode = 1'b1; step();
    check_out("s5_t2", 32'h12345678, 1'b0, 1'b0);
    step();
    check_out("s5_t3", 32'hC0DE0005, 1'b1, 1'b0);
    word_req = 1'b1; step();
    check_out("s5_sync", Sync, 1'b1, 1'b0);
    word_req = 1'b0; step();
    check_out("s5_after", Sync, 1'b0, 1'b0);

    // 6: idle counter saturation (count is 1 already)
    sync_mode = 1'b0; fifo_empty = 1'b1; step();
    word_req = 1'b1;
    repeat (65534) step();
    check("sat.max", {16'b0, idle_cnt}, 32'h0000FFFF);
    step();
    check("sat.hold", {16'b0, idle_cnt}, 32'h0000FFFF);
    check_out("sat.word", Idle, 1'b1, 1'b0);
    word_req = 1'b0; step();

    // 6b: async reset in the middle of a fetch
    fifo_empty = 1'b0; fifo_rd_data = 32'hDEAD0006; word_req = 1'b1; step();
    check_out("mid_fetch", Idle, 1'b0, 1'b1);
    word_req = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    check_out("async_rst", Sync, 1'b0, 1'b0);
    check("async_rst.cnt", {16'b0, idle_cnt}, 32'd0);
    check("async_rst.overrun", {31'b0, req_overrun}, 32'd0);
    step();
    rst_b = 1'b1;
    repeat (3) begin
      step();
      check_out("no_deliver", Sync, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
